// File: rtl/wt_cache_pkg.sv
// Shared definitions for the write-through cache subsystem memory arbiter:
// request source encoding, source-bit width and the default in-flight limit.
package wt_cache_pkg;

    typedef enum logic {
        ICACHE_SRC = 1'b0,
        DCACHE_SRC = 1'b1
    } mem_arb_src_e;

    // Bits prepended to the upstream tid to form the downstream tid.
    localparam int MEM_ARB_SRC_WIDTH = 1;

    localparam int MEM_ARB_MAX_OUTSTANDING = 4;

endpackage

// File: rtl/wt_mem_arb_outstanding_cnt.sv
// Saturating up/down counter of in-flight transactions for one request source,
// with limit-reached and zero flags.
module wt_mem_arb_outstanding_cnt #(
    parameter int MaxOutstanding = 4,
    localparam int CntWidth = $clog2(MaxOutstanding + 1)
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic inc_i,
    input  logic dec_i,
    output logic limit_o,
    output logic zero_o
);

    logic [CntWidth-1:0] count_q;

    assign limit_o = (count_q >= CntWidth'(MaxOutstanding));
    assign zero_o  = (count_q == '0);

    // Simultaneous inc and dec cancel; both directions saturate.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else if (inc_i && !dec_i && !limit_o) begin
            count_q <= count_q + 1'b1;
        end else if (dec_i && !inc_i && !zero_o) begin
            count_q <= count_q - 1'b1;
        end
    end

    // A return with nothing in flight for this source is a protocol error.
    assert property (@(posedge clk_i) disable iff (rst_i) !(dec_i && !inc_i && zero_o));

endmodule

// File: rtl/wt_mem_arbiter.sv
// Merges icache/dcache memory requests into one registered channel and routes
// returns by tid MSB. Define WT_MEM_ARB_DCACHE_PRIO_EN for fixed dcache priority.
module wt_mem_arbiter
    import wt_cache_pkg::*;
#(
    parameter int PayloadWidth   = 128,
    parameter int TidWidth       = 2,
    parameter int RtrnWidth      = 128,
    parameter int MaxOutstanding = MEM_ARB_MAX_OUTSTANDING
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic                              icache_req_i,
    output logic                              icache_ack_o,
    input  logic [PayloadWidth-1:0]           icache_payload_i,
    input  logic [TidWidth-1:0]               icache_tid_i,
    input  logic                              dcache_req_i,
    output logic                              dcache_ack_o,
    input  logic [PayloadWidth-1:0]           dcache_payload_i,
    input  logic [TidWidth-1:0]               dcache_tid_i,
    output logic                              mem_req_o,
    input  logic                              mem_ack_i,
    output logic [PayloadWidth-1:0]           mem_payload_o,
    output logic [TidWidth+MEM_ARB_SRC_WIDTH-1:0] mem_tid_o,
    input  logic                              mem_rtrn_vld_i,
    input  logic [TidWidth+MEM_ARB_SRC_WIDTH-1:0] mem_rtrn_tid_i,
    input  logic [RtrnWidth-1:0]              mem_rtrn_i,
    output logic                              icache_rtrn_vld_o,
    output logic [RtrnWidth-1:0]              icache_rtrn_o,
    output logic [TidWidth-1:0]               icache_rtrn_tid_o,
    output logic                              dcache_rtrn_vld_o,
    output logic [RtrnWidth-1:0]              dcache_rtrn_o,
    output logic [TidWidth-1:0]               dcache_rtrn_tid_o,
    output logic                              idle_o
);

    // Handshakes: upstream req_i is held with stable payload/tid until a
    // single-cycle ack_o; downstream mem_req_o/payload/tid stay stable until
    // mem_ack_i is sampled high on a rising edge. Returns are always accepted.

    logic                                  out_vld_q;
    logic [PayloadWidth-1:0]               out_payload_q;
    logic [TidWidth+MEM_ARB_SRC_WIDTH-1:0] out_tid_q;

    logic         can_capture;
    logic         i_limit, d_limit, i_zero, d_zero;
    logic         i_elig, d_elig;
    logic         grant_i, grant_d;
    logic         rtrn_i, rtrn_d;
    mem_arb_src_e rtrn_src;
    mem_arb_src_e grant_src;

    assign can_capture = !out_vld_q || mem_ack_i;
    assign i_elig      = icache_req_i && !i_limit && can_capture;
    assign d_elig      = dcache_req_i && !d_limit && can_capture;

`ifdef WT_MEM_ARB_DCACHE_PRIO_EN
    assign grant_d = d_elig;
    assign grant_i = i_elig && !d_elig;
`else
    mem_arb_src_e last_q;

    // On a tie the source not granted last wins.
    assign grant_i = i_elig && (!d_elig || last_q == DCACHE_SRC);
    assign grant_d = d_elig && (!i_elig || last_q == ICACHE_SRC);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            last_q <= DCACHE_SRC;
        end else if (grant_i) begin
            last_q <= ICACHE_SRC;
        end else if (grant_d) begin
            last_q <= DCACHE_SRC;
        end
    end
`endif

    assign icache_ack_o = grant_i;
    assign dcache_ack_o = grant_d;
    assign grant_src    = grant_d ? DCACHE_SRC : ICACHE_SRC;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            out_vld_q     <= 1'b0;
            out_payload_q <= '0;
            out_tid_q     <= '0;
        end else if (grant_i || grant_d) begin
            out_vld_q     <= 1'b1;
            out_payload_q <= grant_d ? dcache_payload_i : icache_payload_i;
            out_tid_q     <= {grant_src, (grant_d ? dcache_tid_i : icache_tid_i)};
        end else if (mem_ack_i) begin
            out_vld_q     <= 1'b0;
        end
    end

    assign mem_req_o     = out_vld_q;
    assign mem_payload_o = out_payload_q;
    assign mem_tid_o     = out_tid_q;

    assign rtrn_src = mem_arb_src_e'(mem_rtrn_tid_i[TidWidth]);
    assign rtrn_i   = mem_rtrn_vld_i && (rtrn_src == ICACHE_SRC);
    assign rtrn_d   = mem_rtrn_vld_i && (rtrn_src == DCACHE_SRC);

    assign icache_rtrn_vld_o = rtrn_i;
    assign dcache_rtrn_vld_o = rtrn_d;
    assign icache_rtrn_o     = mem_rtrn_i;
    assign dcache_rtrn_o     = mem_rtrn_i;
    assign icache_rtrn_tid_o = mem_rtrn_tid_i[TidWidth-1:0];
    assign dcache_rtrn_tid_o = mem_rtrn_tid_i[TidWidth-1:0];

    wt_mem_arb_outstanding_cnt #(
        .MaxOutstanding(MaxOutstanding)
    ) u_icache_cnt (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .inc_i  (grant_i),
        .dec_i  (rtrn_i),
        .limit_o(i_limit),
        .zero_o (i_zero)
    );

    wt_mem_arb_outstanding_cnt #(
        .MaxOutstanding(MaxOutstanding)
    ) u_dcache_cnt (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .inc_i  (grant_d),
        .dec_i  (rtrn_d),
        .limit_o(d_limit),
        .zero_o (d_zero)
    );

    assign idle_o = !out_vld_q && i_zero && d_zero;

endmodule

// File: tb/tb_wt_mem_arbiter.sv
// Directed self-checking bench for wt_mem_arbiter; honours
// WT_MEM_ARB_DCACHE_PRIO_EN for the arbitration-order expectations.
module tb_wt_mem_arbiter;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic         icache_req_i, dcache_req_i;
    logic         icache_ack_o, dcache_ack_o;
    logic [127:0] icache_payload_i, dcache_payload_i;
    logic [1:0]   icache_tid_i, dcache_tid_i;
    logic         mem_req_o, mem_ack_i;
    logic [127:0] mem_payload_o;
    logic [2:0]   mem_tid_o;
    logic         mem_rtrn_vld_i;
    logic [2:0]   mem_rtrn_tid_i;
    logic [127:0] mem_rtrn_i;
    logic         icache_rtrn_vld_o, dcache_rtrn_vld_o;
    logic [127:0] icache_rtrn_o, dcache_rtrn_o;
    logic [1:0]   icache_rtrn_tid_o, dcache_rtrn_tid_o;
    logic         idle_o;

    int n_checks = 0;
    int n_fail   = 0;
    logic [2:0] exp_q[$];

    wt_mem_arbiter dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .icache_req_i     (icache_req_i),
        .icache_ack_o     (icache_ack_o),
        .icache_payload_i (icache_payload_i),
        .icache_tid_i     (icache_tid_i),
        .dcache_req_i     (dcache_req_i),
        .dcache_ack_o     (dcache_ack_o),
        .dcache_payload_i (dcache_payload_i),
        .dcache_tid_i     (dcache_tid_i),
        .mem_req_o        (mem_req_o),
        .mem_ack_i        (mem_ack_i),
        .mem_payload_o    (mem_payload_o),
        .mem_tid_o        (mem_tid_o),
        .mem_rtrn_vld_i   (mem_rtrn_vld_i),
        .mem_rtrn_tid_i   (mem_rtrn_tid_i),
        .mem_rtrn_i       (mem_rtrn_i),
        .icache_rtrn_vld_o(icache_rtrn_vld_o),
        .icache_rtrn_o    (icache_rtrn_o),
        .icache_rtrn_tid_o(icache_rtrn_tid_o),
        .dcache_rtrn_vld_o(dcache_rtrn_vld_o),
        .dcache_rtrn_o    (dcache_rtrn_o),
        .dcache_rtrn_tid_o(dcache_rtrn_tid_o),
        .idle_o           (idle_o)
    );

    // Clock / reset
    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1);
    end

    // Driver tasks: step returns 1 time unit after a rising edge, settle lets
    // combinational outputs react to freshly driven inputs.
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic clear_inputs();
        icache_req_i     = 1'b0;
        dcache_req_i     = 1'b0;
        icache_payload_i = '0;
        dcache_payload_i = '0;
        icache_tid_i     = '0;
        dcache_tid_i     = '0;
        mem_ack_i        = 1'b0;
        mem_rtrn_vld_i   = 1'b0;
        mem_rtrn_tid_i   = '0;
        mem_rtrn_i       = '0;
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        clear_inputs();
        step();
        step();
        rst_i = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        settle();
        n_checks++; if (mem_req_o !== 1'b0) begin n_fail++; $display("FAIL reset_mem_req: got %0b required 0", mem_req_o); end
        n_checks++; if ({icache_ack_o, dcache_ack_o} !== 2'b00) begin n_fail++; $display("FAIL reset_acks: got %b required 00", {icache_ack_o, dcache_ack_o}); end
        n_checks++; if ({icache_rtrn_vld_o, dcache_rtrn_vld_o} !== 2'b00) begin n_fail++; $display("FAIL reset_rtrn_vld: got %b required 00", {icache_rtrn_vld_o, dcache_rtrn_vld_o}); end
        n_checks++; if (idle_o !== 1'b1) begin n_fail++; $display("FAIL reset_idle: got %0b required 1", idle_o); end
    endtask

    task automatic test_single_icache();
        do_reset();
        icache_req_i     = 1'b1;
        icache_tid_i     = 2'd2;
        icache_payload_i = {4{32'hA5A5_0001}};
        mem_ack_i        = 1'b1;
        settle();
        n_checks++; if (icache_ack_o !== 1'b1) begin n_fail++; $display("FAIL single_ack_c1: got %0b required 1", icache_ack_o); end
        step();
        icache_req_i = 1'b0;
        settle();
        n_checks++; if (mem_req_o !== 1'b1 || mem_tid_o !== 3'b010) begin n_fail++; $display("FAIL single_mem_c2: got req %0b tid %b required req 1 tid 010", mem_req_o, mem_tid_o); end
        n_checks++; if (mem_payload_o !== {4{32'hA5A5_0001}}) begin n_fail++; $display("FAIL single_payload: got %h required %h", mem_payload_o, {4{32'hA5A5_0001}}); end
        n_checks++; if (idle_o !== 1'b0) begin n_fail++; $display("FAIL single_idle_busy: got %0b required 0", idle_o); end
        step();
        settle();
        n_checks++; if (mem_req_o !== 1'b0 || idle_o !== 1'b0) begin n_fail++; $display("FAIL single_drained: got req %0b idle %0b required req 0 idle 0", mem_req_o, idle_o); end
        mem_rtrn_vld_i = 1'b1;
        mem_rtrn_tid_i = 3'b010;
        mem_rtrn_i     = {4{32'hC0DE_0002}};
        settle();
        n_checks++; if ({icache_rtrn_vld_o, dcache_rtrn_vld_o} !== 2'b10) begin n_fail++; $display("FAIL single_rtrn_route: got %b required 10", {icache_rtrn_vld_o, dcache_rtrn_vld_o}); end
        n_checks++; if (icache_rtrn_tid_o !== 2'd2 || icache_rtrn_o !== {4{32'hC0DE_0002}}) begin n_fail++; $display("FAIL single_rtrn_data: got tid %0d data %h required tid 2 data %h", icache_rtrn_tid_o, icache_rtrn_o, {4{32'hC0DE_0002}}); end
        step();
        mem_rtrn_vld_i = 1'b0;
        settle();
        n_checks++; if (idle_o !== 1'b1) begin n_fail++; $display("FAIL single_idle_after_rtrn: got %0b required 1", idle_o); end
    endtask

    task automatic test_back_to_back();
        logic       exp_d;
        logic [2:0] exp_tid;
        do_reset();
        icache_req_i     = 1'b1;
        dcache_req_i     = 1'b1;
        icache_tid_i     = 2'd1;
        dcache_tid_i     = 2'd3;
        icache_payload_i = {4{32'h1111_1111}};
        dcache_payload_i = {4{32'hDDDD_DDDD}};
        mem_ack_i        = 1'b1;
        for (int k = 0; k < 4; k++) begin
            settle();
`ifdef WT_MEM_ARB_DCACHE_PRIO_EN
            exp_d = 1'b1;
`else
            exp_d = (k % 2 == 1);
`endif
            n_checks++; if ({icache_ack_o, dcache_ack_o} !== {~exp_d, exp_d}) begin n_fail++; $display("FAIL b2b_grant[%0d]: got i%0b d%0b required i%0b d%0b", k, icache_ack_o, dcache_ack_o, ~exp_d, exp_d); end
            exp_q.push_back(exp_d ? 3'b111 : 3'b001);
            step();
            exp_tid = (exp_q.size() > 0) ? exp_q.pop_front() : 3'bxxx;
            n_checks++; if (mem_req_o !== 1'b1 || mem_tid_o !== exp_tid) begin n_fail++; $display("FAIL b2b_mem_tid[%0d]: got req %0b tid %b required req 1 tid %b", k, mem_req_o, mem_tid_o, exp_tid); end
        end
        icache_req_i = 1'b0;
        dcache_req_i = 1'b0;
    endtask

    task automatic test_limit();
        do_reset();
        dcache_req_i     = 1'b1;
        dcache_payload_i = {4{32'h0BAD_F00D}};
        mem_ack_i        = 1'b1;
        for (int k = 0; k < 4; k++) begin
            dcache_tid_i = 2'(k);
            settle();
            n_checks++; if (dcache_ack_o !== 1'b1) begin n_fail++; $display("FAIL limit_fill_ack[%0d]: got %0b required 1", k, dcache_ack_o); end
            step();
        end
        dcache_tid_i = 2'd0;
        settle();
        n_checks++; if (dcache_ack_o !== 1'b0) begin n_fail++; $display("FAIL limit_5th_ack: got %0b required 0", dcache_ack_o); end
        step();
        settle();
        n_checks++; if (dcache_ack_o !== 1'b0) begin n_fail++; $display("FAIL limit_hold_ack: got %0b required 0", dcache_ack_o); end
        mem_rtrn_vld_i = 1'b1;
        mem_rtrn_tid_i = 3'b101;
        mem_rtrn_i     = {4{32'h5555_AAAA}};
        settle();
        n_checks++; if ({icache_rtrn_vld_o, dcache_rtrn_vld_o} !== 2'b01 || dcache_rtrn_tid_o !== 2'd1) begin n_fail++; $display("FAIL limit_rtrn_route: got vld %b tid %0d required vld 01 tid 1", {icache_rtrn_vld_o, dcache_rtrn_vld_o}, dcache_rtrn_tid_o); end
        n_checks++; if (dcache_ack_o !== 1'b0) begin n_fail++; $display("FAIL limit_ack_same_cycle_as_rtrn: got %0b required 0", dcache_ack_o); end
        step();
        mem_rtrn_vld_i = 1'b0;
        settle();
        n_checks++; if (dcache_ack_o !== 1'b1) begin n_fail++; $display("FAIL limit_ack_after_rtrn: got %0b required 1", dcache_ack_o); end
        step();
        dcache_req_i = 1'b0;
        settle();
        n_checks++; if (mem_req_o !== 1'b1 || mem_tid_o !== 3'b100) begin n_fail++; $display("FAIL limit_regrant_tid: got req %0b tid %b required req 1 tid 100", mem_req_o, mem_tid_o); end
    endtask

    task automatic test_backpressure();
        do_reset();
        icache_req_i     = 1'b1;
        icache_tid_i     = 2'd1;
        icache_payload_i = {4{32'hFACE_0001}};
        settle();
        n_checks++; if (icache_ack_o !== 1'b1) begin n_fail++; $display("FAIL bp_first_ack: got %0b required 1", icache_ack_o); end
        step();
        icache_tid_i     = 2'd2;
        icache_payload_i = {4{32'hFACE_0002}};
        for (int k = 0; k < 5; k++) begin
            settle();
            n_checks++; if (mem_req_o !== 1'b1 || mem_payload_o !== {4{32'hFACE_0001}} || mem_tid_o !== 3'b001) begin n_fail++; $display("FAIL bp_hold[%0d]: got req %0b tid %b payload %h required req 1 tid 001 payload %h", k, mem_req_o, mem_tid_o, mem_payload_o, {4{32'hFACE_0001}}); end
            n_checks++; if (icache_ack_o !== 1'b0) begin n_fail++; $display("FAIL bp_no_ack[%0d]: got %0b required 0", k, icache_ack_o); end
            step();
        end
        mem_ack_i = 1'b1;
        settle();
        n_checks++; if (icache_ack_o !== 1'b1) begin n_fail++; $display("FAIL bp_ack_on_drain: got %0b required 1", icache_ack_o); end
        step();
        icache_req_i = 1'b0;
        settle();
        n_checks++; if (mem_req_o !== 1'b1 || mem_tid_o !== 3'b010 || mem_payload_o !== {4{32'hFACE_0002}}) begin n_fail++; $display("FAIL bp_second: got req %0b tid %b payload %h required req 1 tid 010 payload %h", mem_req_o, mem_tid_o, mem_payload_o, {4{32'hFACE_0002}}); end
        step();
        settle();
        n_checks++; if (mem_req_o !== 1'b0) begin n_fail++; $display("FAIL bp_empty: got %0b required 0", mem_req_o); end
    endtask

    task automatic test_grant_and_return();
        do_reset();
        icache_req_i = 1'b1;
        icache_tid_i = 2'd0;
        mem_ack_i    = 1'b1;
        step();
        icache_tid_i   = 2'd1;
        mem_rtrn_vld_i = 1'b1;
        mem_rtrn_tid_i = 3'b000;
        mem_rtrn_i     = {4{32'h0123_4567}};
        settle();
        n_checks++; if (icache_ack_o !== 1'b1) begin n_fail++; $display("FAIL gr_ack: got %0b required 1", icache_ack_o); end
        n_checks++; if ({icache_rtrn_vld_o, dcache_rtrn_vld_o} !== 2'b10 || icache_rtrn_tid_o !== 2'd0) begin n_fail++; $display("FAIL gr_rtrn: got vld %b tid %0d required vld 10 tid 0", {icache_rtrn_vld_o, dcache_rtrn_vld_o}, icache_rtrn_tid_o); end
        step();
        icache_req_i   = 1'b0;
        mem_rtrn_vld_i = 1'b0;
        settle();
        n_checks++; if (dut.u_icache_cnt.count_q !== 3'd1) begin n_fail++; $display("FAIL gr_count: got %0d required 1", dut.u_icache_cnt.count_q); end
        n_checks++; if (icache_rtrn_vld_o !== 1'b0) begin n_fail++; $display("FAIL gr_rtrn_pulse: got %0b required 0", icache_rtrn_vld_o); end
    endtask

    task automatic test_reset_mid_transaction();
        do_reset();
        icache_req_i = 1'b1;
        mem_ack_i    = 1'b1;
        for (int k = 0; k < 3; k++) begin
            icache_tid_i = 2'(k);
            step();
        end
        icache_req_i = 1'b0;
        mem_ack_i    = 1'b0;
        settle();
        n_checks++; if (mem_req_o !== 1'b1 || idle_o !== 1'b0) begin n_fail++; $display("FAIL rst_mid_pre: got req %0b idle %0b required req 1 idle 0", mem_req_o, idle_o); end
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        settle();
        n_checks++; if (mem_req_o !== 1'b0 || idle_o !== 1'b1) begin n_fail++; $display("FAIL rst_mid_outputs: got req %0b idle %0b required req 0 idle 1", mem_req_o, idle_o); end
        n_checks++; if ({icache_ack_o, dcache_ack_o, icache_rtrn_vld_o, dcache_rtrn_vld_o} !== 4'b0000) begin n_fail++; $display("FAIL rst_mid_strobes: got %b required 0000", {icache_ack_o, dcache_ack_o, icache_rtrn_vld_o, dcache_rtrn_vld_o}); end
        step();
        settle();
        n_checks++; if (idle_o !== 1'b1 || dut.u_icache_cnt.count_q !== 3'd0) begin n_fail++; $display("FAIL rst_mid_after: got idle %0b count %0d required idle 1 count 0", idle_o, dut.u_icache_cnt.count_q); end
    endtask

    initial begin
        rst_i = 1'b1;
        clear_inputs();
        test_reset();
        test_single_icache();
        test_back_to_back();
        test_limit();
        test_backpressure();
        test_grant_and_return();
        test_reset_mid_transaction();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
